dmem_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer in front of the byte-addressed data memory.
- Port 0 is the CPU load/store path; port 1 is the loader/debug path that preloads and inspects data memory.
- Serialises requests onto a single memory port using round-robin grant, and checks alignment and range before any access.
- Returns read data, or an error, to the owning requester only.

---
 rtl/dmem_arbiter_pkg.sv | 47 ++++
 rtl/dmem_access_check.sv | 27 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: load/store funct3 codes,
// sequencer states, the latched request record and small decode helpers.
package dmem_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Unsigned sizes only exist for loads; stores accept byte/half/word.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LH, F3_LW: funct3_legal = 1'b1;
            F3_LBU, F3_LHU:      funct3_legal = !we;
            default:             funct3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   is_misaligned = addr_lo[0];
            2'b10:   is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for one data-memory access: size/sign code,
// natural alignment and implemented address range.
module dmem_access_check
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_BITS  = 17
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    output logic                  err
);

    logic misaligned;
    logic out_of_range;
    logic bad_funct3;

    // Any bit set above the implemented range means addr >= 2**ADDR_BITS.
    always_comb begin
        misaligned   = is_misaligned(funct3, addr[1:0]);
        out_of_range = ((addr >> ADDR_BITS) != '0);
        bad_funct3   = !funct3_legal(we, funct3);
        err          = misaligned | out_of_range | bad_funct3;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug path.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_BITS  = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][2:0]            req_funct3,
    input  logic [1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 resp_valid,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err,
    output logic                       mem_en,
    output logic                       mem_wen,
    output logic [2:0]                 mem_funct3,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  owner;
    dmem_req_t             req_q;
    dmem_req_t             sel_req;
    logic                  grant;
    logic                  accept;
    logic                  access_err;
    logic [DATA_WIDTH-1:0] load_data;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        req_ready      = (state == IDLE) ? (req_valid & (2'b01 << grant)) : 2'b00;
        accept         = |req_ready;
        sel_req.we     = req_we[grant];
        sel_req.funct3 = req_funct3[grant];
        sel_req.addr   = req_addr[grant];
        sel_req.wdata  = req_wdata[grant];
    end

    dmem_access_check #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_check (
        .we    (sel_req.we),
        .funct3(sel_req.funct3),
        .addr  (sel_req.addr),
        .err   (access_err)
    );

    // Memory returns LSB-aligned data; sign/zero extension happens here.
    always_comb begin
        load_data = mem_rdata;
        case (req_q.funct3)
            F3_LB:   load_data = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
            F3_LH:   load_data = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Erroring requests skip the memory entirely and never update req_q,
    // so an out-of-range address cannot appear on mem_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            req_q      <= '0;
            resp_valid <= 2'b00;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_wen    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (access_err) begin
                            resp_valid <= 2'b01 << grant;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            req_q   <= sel_req;
                            mem_en  <= 1'b1;
                            mem_wen <= sel_req.we;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_wen <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    resp_rdata <= req_q.we ? '0 : load_data;
                    resp_valid <= 2'b01 << owner;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 2'b00;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_funct3 = req_q.funct3;
    assign mem_addr   = req_q.addr;
    assign mem_wdata  = req_q.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model plus a scoreboard of
// expected memory strobes and responses, checked on the falling edge.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             mem_en;
    logic             mem_wen;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic        wen;
    } memx_t;

    resp_t     respq[$];
    memx_t     memq[$];
    resp_t     rcur;
    memx_t     mcur;
    vec_t      vecs[15];
    bit [7:0]  memb[bit [31:0]];

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_funct3(mem_funct3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns raw LSB-aligned bytes one cycle after a read strobe,
    // and a poison pattern otherwise so a mistimed capture shows up.
    always @(posedge clk) begin
        if (mem_en && mem_wen) begin
            memb[mem_addr] = mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) memb[mem_addr + 32'd1] = mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                memb[mem_addr + 32'd2] = mem_wdata[23:16];
                memb[mem_addr + 32'd3] = mem_wdata[31:24];
            end
        end
        if (mem_en && !mem_wen) begin
            case (mem_funct3[1:0])
                2'b00:   mem_rdata <= {24'h0, memb[mem_addr]};
                2'b01:   mem_rdata <= {16'h0, memb[mem_addr + 32'd1], memb[mem_addr]};
                default: mem_rdata <= {memb[mem_addr + 32'd3], memb[mem_addr + 32'd2],
                                       memb[mem_addr + 32'd1], memb[mem_addr]};
            endcase
        end else begin
            mem_rdata <= 32'hBAD0BAD0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: expected event did not occur or was unexpected (cycle %0d)", name, cyc);
    endtask

    // Called at the falling edge of the accept cycle.
    task automatic pushExpect(input int port, input logic we, input logic [31:0] addr,
                              input logic err, input logic [31:0] rdata, input bit withResp);
        if (!err) memq.push_back('{due: cyc + 1, addr: addr, wen: we});
        if (withResp) respq.push_back('{port: port, err: err, rdata: rdata, due: cyc + (err ? 1 : 3)});
    endtask

    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (memq.size() == 0) failNow("mem_unexpected");
            else begin
                mcur = memq.pop_front();
                checkOutput("mem_cycle", 32'(cyc), 32'(mcur.due));
                checkOutput("mem_addr", mem_addr, mcur.addr);
                checkOutput("mem_wen", {31'h0, mem_wen}, {31'h0, mcur.wen});
            end
        end
        if (resp_valid !== 2'b00 && !$isunknown(resp_valid)) begin
            if (respq.size() == 0) failNow("resp_unexpected");
            else begin
                rcur = respq.pop_front();
                checkOutput("resp_owner", {30'h0, resp_valid}, (rcur.port == 0) ? 32'h1 : 32'h2);
                checkOutput("resp_err", {31'h0, resp_err}, {31'h0, rcur.err});
                checkOutput("resp_rdata", resp_rdata, rcur.rdata);
                checkOutput("resp_cycle", 32'(cyc), 32'(rcur.due));
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_resp_valid"}, {30'h0, resp_valid}, 32'h0);
        checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        checkOutput({tag, "_mem_en"}, {31'h0, mem_en}, 32'h0);
        checkOutput({tag, "_mem_wen"}, {31'h0, mem_wen}, 32'h0);
        checkOutput({tag, "_mem_funct3"}, {29'h0, mem_funct3}, 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drivePort(input int port, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_we[port]     = we;
        req_funct3[port] = f3;
        req_addr[port]   = addr;
        req_wdata[port]  = wdata;
        req_valid[port]  = 1'b1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40; i++) begin
            if (respq.size() == 0 && memq.size() == 0) break;
            @(negedge clk);
        end
        if (respq.size() != 0 || memq.size() != 0) begin
            failNow("drain_timeout");
            respq.delete();
            memq.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1 drivePort(v.port, v.we, v.f3, v.addr, v.wdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[v.port] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) failNow("accept_timeout");
        else pushExpect(v.port, v.we, v.addr, v.err, v.rdata, 1'b1);
        @(posedge clk);
        #1 req_valid[v.port] = 1'b0;
        waitDrain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int got[$];
        int cnt[2];
        int g;

        vecs[0]  = '{0, 1'b1, F3_SW,  32'h10000, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, F3_LW,  32'h10000, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b0, F3_LH,  32'h10001, 32'h0,        1'b1, 32'h0};
        vecs[3]  = '{0, 1'b0, F3_LW,  32'h20000, 32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1, 1'b1, F3_SB,  32'h10004, 32'h12345680, 1'b0, 32'h0};
        vecs[5]  = '{0, 1'b0, F3_LB,  32'h10004, 32'h0,        1'b0, 32'hFFFFFF80};
        vecs[6]  = '{1, 1'b0, F3_LBU, 32'h10004, 32'h0,        1'b0, 32'h00000080};
        vecs[7]  = '{0, 1'b1, F3_SH,  32'h10006, 32'h1234ABCD, 1'b0, 32'h0};
        vecs[8]  = '{1, 1'b0, F3_LH,  32'h10006, 32'h0,        1'b0, 32'hFFFFABCD};
        vecs[9]  = '{0, 1'b0, F3_LHU, 32'h10006, 32'h0,        1'b0, 32'h0000ABCD};
        vecs[10] = '{1, 1'b0, F3_LW,  32'h10004, 32'h0,        1'b0, 32'hABCD0080};
        vecs[11] = '{0, 1'b1, F3_SW,  32'h10002, 32'h55555555, 1'b1, 32'h0};
        vecs[12] = '{1, 1'b1, 3'b100, 32'h10008, 32'h66666666, 1'b1, 32'h0};
        vecs[13] = '{0, 1'b0, 3'b011, 32'h10008, 32'h0,        1'b1, 32'h0};
        vecs[14] = '{1, 1'b0, F3_LW,  32'h1FFFC, 32'h0,        1'b0, 32'h0};

        req_valid  = 2'b00;
        req_we     = 2'b00;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;

        $display("[TB] reset and idle outputs");
        doReset();
        @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_req_ready", {30'h0, req_ready}, 32'h0);

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

        $display("[TB] fairness with both ports valid");
        doReset();
        cnt[0] = 0;
        cnt[1] = 0;
        @(posedge clk);
        #1;
        drivePort(0, 1'b0, F3_LW, 32'h10000, 32'h0);
        drivePort(1, 1'b0, F3_LBU, 32'h10004, 32'h0);
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clk);
            if (req_ready !== 2'b00 && !$isunknown(req_ready)) begin
                g = req_ready[1] ? 1 : 0;
                got.push_back(g);
                if (g == 0) pushExpect(0, 1'b0, 32'h10000, 1'b0, 32'hDEADBEEF, 1'b1);
                else        pushExpect(1, 1'b0, 32'h10004, 1'b0, 32'h00000080, 1'b1);
                cnt[g]++;
                @(posedge clk);
                #1 if (cnt[g] >= 2) req_valid[g] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) checkOutput($sformatf("grant_order_%0d", k), 32'(got[k]), 32'(k % 2));
            else failNow($sformatf("grant_order_%0d", k));
        end
        req_valid = 2'b00;
        waitDrain();

        $display("[TB] reset during a load in WAIT");
        @(posedge clk);
        #1 drivePort(0, 1'b0, F3_LW, 32'h10000, 32'h0);
        g = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[0] === 1'b1) begin
                g = 0;
                break;
            end
        end
        if (g != 0) failNow("midreset_accept_timeout");
        else pushExpect(0, 1'b0, 32'h10000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drivePort(0, 1'b0, F3_LW, 32'h10000, 32'h0);
        drivePort(1, 1'b0, F3_LW, 32'h10000, 32'h0);
        @(negedge clk);
        checkIdleOutputs("midreset");
        checkOutput("midreset_first_grant", {30'h0, req_ready}, 32'h1);
        if (req_ready === 2'b01) pushExpect(0, 1'b0, 32'h10000, 1'b0, 32'hDEADBEEF, 1'b1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        waitDrain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
